instruction_decode: RTL
=======================

# instruction_decode

Decode stage directly downstream of the instruction fetch unit in the RV32I core. It accepts one fetched instruction and PC per cycle through a valid/ready handshake and holds it in the IF/ID pipeline register. It produces registered decoded fields, the sign-extended immediate and both register-file operands for the execute stage. It contains the 32x32 integer register file, whose write port is driven by writeback.

## Interface
- `NOP_INSTR`, default 32'h0000_0013: encoding driven on `id_instruction` while the stage holds no valid entry.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `if_valid`  in  1  fetch presents an instruction this cycle.
- `if_pc`  in  32  PC of the presented instruction.
- `if_instruction`  in  32  presented instruction word.
- `id_ready`  out  1  stage accepts from fetch this cycle.
- `flush`  in  1  kill the held entry (branch taken in execute).
- `ex_ready`  in  1  execute accepts the held entry this cycle.
- `wb_we`  in  1  register-file write enable.
- `wb_rd`  in  5  write address.
- `wb_data`  in  32  write data.
- `id_valid`  out  1  held entry is valid.
- `id_pc`  out  32  PC of the held instruction.
- `id_instruction`  out  32  held instruction word.
- `id_opcode`  out  7  decoded opcode field.
- `id_funct3`  out  3  decoded funct3 field.
- `id_funct7`  out  7  decoded funct7 field.
- `id_rs1`  out  5  source register 1 address.
- `id_rs2`  out  5  source register 2 address.
- `id_rd`  out  5  destination register address.
- `id_imm`  out  32  sign-extended immediate.
- `id_rs1_data`  out  32  operand read from `id_rs1`.
- `id_rs2_data`  out  32  operand read from `id_rs2`.
- `id_illegal`  out  1  held instruction is not a legal RV32I encoding.

## Operation
- `id_ready = !id_valid || ex_ready`. The output is combinational and has no dependence on `flush`.
- Load happens when `if_valid && id_ready && !flush`. On load the stage captures the PC and instruction, all decoded fields, the immediate and both operands. `id_valid` becomes 1.
- When `id_valid && ex_ready` and nothing is loaded, `id_valid` becomes 0.
- When `id_valid && !ex_ready`, the stage holds and every output stays stable, except for the operand refresh described below.
- `flush` clears `id_valid` at the next edge and takes priority over load and hold. The instruction presented in a flush cycle is discarded.
- While `id_valid` is 0, `id_instruction` shows `NOP_INSTR` and the decoded fields show its decode: rd=0, imm=0, illegal=0.
- Immediate decode by opcode:
  - I-type: 0000011, 0010011, 1100111, 1110011.
  - S-type: 0100011.
  - B-type: 1100011, bit 0 is 0.
  - U-type: 0110111, 0010111.
  - J-type: 1101111, bit 0 is 0.
  - R-type (0110011): imm = 0.
- All immediates are sign-extended from instruction bit 31.
- `id_illegal` is set if `instruction[1:0] != 2'b11` or the opcode is outside the set {0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111, 0001111, 1110011}.
- An illegal instruction still passes through the stage, with `id_rd` forced to 0.
- Register file:
  - x1..x31 are cleared by reset.
  - A write happens at the rising edge when `wb_we && wb_rd != 0`.
  - x0 always reads 0, and writes to x0 are ignored.
- Write-through on load: if the same cycle writes `wb_rd == rs` with rs != 0, the loaded operand is `wb_data`.
- Operand refresh during hold: if `id_valid` and a write hits `id_rs1` or `id_rs2` (nonzero), the matching held operand takes `wb_data` at that edge.

## Timing
- Reset (asynchronous assert):
  - `id_valid`=0.
  - `id_pc`=0.
  - `id_instruction`=`NOP_INSTR`.
  - All other outputs 0, including the rs/rd addresses and the operands.
  - Register file cleared.
- Deassertion takes effect at the first rising edge after `reset_n` rises.
- Latency: an instruction accepted at edge N appears on the outputs after edge N, with `id_valid`=1 during cycle N+1.
- Throughput: one instruction per cycle while `ex_ready`=1.
- Simultaneous load and drain in the same cycle gives back-to-back valid entries with no bubble.
- Simultaneous `flush` and `if_valid` gives `id_valid`=0 in the next cycle.
- A writeback and a load of a dependent instruction in the same cycle give a bypassed operand, with no extra stall.
- Reset asserted mid-stream drops the held entry immediately.

## Test plan
- Reset then idle:
  - Stimulus: hold `reset_n`=0, then release, with `if_valid`=0.
  - Required: `id_valid`=0, `id_instruction`=32'h00000013, `id_ready`=1, and `id_rs1_data` reads 0 for all rs1.
- Decode and immediate:
  - Stimulus: feed 32'hFFF00093 (addi x1,x0,-1) at PC 0x10.
  - Required, next cycle: `id_imm`=32'hFFFFFFFF, `id_rd`=1, `id_pc`=0x10.
  - Stimulus: feed 32'hFE000EE3 (beq x0,x0,-4).
  - Required: `id_imm`=32'hFFFFFFFC.
- Stall and refresh:
  - Stimulus: with `ex_ready`=0, hold `add x3,x1,x2`, then write x1=0xDEAD_BEEF.
  - Required: `id_rs1_data` changes to 0xDEADBEEF and every other output stays constant.
  - Also required: `id_ready`=0 while held.
- Write-through:
  - Stimulus: load `add x5,x4,x4` in the same cycle as `wb_we`=1, `wb_rd`=4, `wb_data`=7.
  - Required: both operands = 7.
  - Also required: a write to x0 with data 5 leaves x0 reading 0.
- Flush priority:
  - Stimulus: assert `flush` together with `if_valid`=1 while an entry is held.
  - Required: `id_valid`=0 next cycle and the presented instruction never appears on the outputs.
- Illegal and back-to-back:
  - Stimulus: feed 32'h00000000.
  - Required: `id_illegal`=1, `id_rd`=0.
  - Stimulus: feed four instructions with `ex_ready`=1.
  - Required: four consecutive `id_valid` cycles.

Source files
------------

// File: rtl/instruction_decode_if.sv
// ---------------------------------------------------------------------------
// instruction_decode_if
// Purpose : Groups the fetch handshake, execute handshake, writeback port and
//           the decoded outputs of the decode stage into one bundle.
// Modports:
//   master - environment side. It drives fetch (if_*), flush, ex_ready and
//            the writeback port (wb_*), and it observes the id_* outputs.
//   slave  - decode stage side. It consumes those inputs and drives id_*.
// Signals : if_valid/if_pc/if_instruction  fetch offer
//           id_ready                       decode can accept this cycle
//           flush                          kill the held entry
//           ex_ready                       execute takes the held entry
//           wb_we/wb_rd/wb_data            register-file write port
//           id_*                           held entry and its decode
// ---------------------------------------------------------------------------
interface instruction_decode_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        id_ready;
  logic        flush;
  logic        ex_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] id_imm;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic        id_illegal;

  modport master (
    output if_valid, if_pc, if_instruction, flush, ex_ready,
           wb_we, wb_rd, wb_data,
    input  id_ready, id_valid, id_pc, id_instruction, id_opcode, id_funct3,
           id_funct7, id_rs1, id_rs2, id_rd, id_imm, id_rs1_data,
           id_rs2_data, id_illegal
  );

  modport slave (
    input  if_valid, if_pc, if_instruction, flush, ex_ready,
           wb_we, wb_rd, wb_data,
    output id_ready, id_valid, id_pc, id_instruction, id_opcode, id_funct3,
           id_funct7, id_rs1, id_rs2, id_rd, id_imm, id_rs1_data,
           id_rs2_data, id_illegal
  );
endinterface

// File: rtl/instruction_decode.sv
// ---------------------------------------------------------------------------
// instruction_decode
// Purpose : RV32I decode stage. It takes one instruction per cycle from fetch
//           and holds it in the IF/ID register together with its decoded
//           fields, its sign-extended immediate and both register operands.
//           The 32x32 integer register file lives here, and writeback drives
//           its write port.
// Ports   : clk      rising-edge clock
//           reset_n  asynchronous active-low reset
//           bus      instruction_decode_if.slave. It carries the fetch
//                    handshake, flush, ex_ready, the writeback port and all
//                    id_* outputs.
// Param   : NOP_INSTR  word shown on id_instruction while no entry is held.
// ---------------------------------------------------------------------------
module instruction_decode #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                  clk,
  input logic                  reset_n,
  instruction_decode_if.slave  bus
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Sign-extended immediate, selected by the instruction format. R-type,
  // fence and unknown opcodes yield zero.
  function automatic logic signed [31:0] f_imm(input logic [31:0] ins);
    logic signed [31:0] imm;
    case (ins[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:
        imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {ins[31:12], 12'h000};
      OP_JAL:
        imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:
        imm = 32'sd0;
    endcase
    return imm;
  endfunction

  function automatic logic f_illegal(input logic [31:0] ins);
    logic ill;
    case (ins[6:0])
      OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
      OP_JAL, OP_JALR, OP_FENCE, OP_SYSTEM: ill = 1'b0;
      default:                              ill = 1'b1;
    endcase
    return ill || (ins[1:0] != 2'b11);
  endfunction

  // -------------------------------------------------------------------------
  // Stage p0: handshake, decode of the fetched word, operand read
  // -------------------------------------------------------------------------
  logic               r_vld_p1;
  logic [31:0]        r_rf [0:31];

  logic               w_ready;
  logic               w_load;
  logic               w_drain;
  logic               w_wr_en;
  logic [31:0]        w_ins_p0;
  logic [4:0]         w_rs1_p0;
  logic [4:0]         w_rs2_p0;
  logic               w_ill_p0;
  logic [4:0]         w_rd_p0;
  logic signed [31:0] w_imm_p0;
  logic [31:0]        w_rs1_data_p0;
  logic [31:0]        w_rs2_data_p0;

  assign w_ready  = !r_vld_p1 || bus.ex_ready;
  assign w_load   = bus.if_valid && w_ready && !bus.flush;
  assign w_drain  = r_vld_p1 && bus.ex_ready;
  // Entry 0 is never written, so x0 reads back as zero without a special case.
  assign w_wr_en  = bus.wb_we && (bus.wb_rd != 5'd0);

  assign w_ins_p0 = bus.if_instruction;
  assign w_rs1_p0 = w_ins_p0[19:15];
  assign w_rs2_p0 = w_ins_p0[24:20];
  assign w_ill_p0 = f_illegal(w_ins_p0);
  // An illegal word still flows to execute, but it must never name a target.
  assign w_rd_p0  = w_ill_p0 ? 5'd0 : w_ins_p0[11:7];
  assign w_imm_p0 = f_imm(w_ins_p0);

  // A writeback landing in the load cycle is forwarded. The dependent
  // instruction therefore picks up the new value with no stall.
  always_comb begin
    w_rs1_data_p0 = r_rf[w_rs1_p0];
    w_rs2_data_p0 = r_rf[w_rs2_p0];
    if (w_wr_en && (bus.wb_rd == w_rs1_p0)) w_rs1_data_p0 = bus.wb_data;
    if (w_wr_en && (bus.wb_rd == w_rs2_p0)) w_rs2_data_p0 = bus.wb_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'h0;
    end else if (w_wr_en) begin
      r_rf[bus.wb_rd] <= bus.wb_data;
    end
  end

  // -------------------------------------------------------------------------
  // Stage p1: IF/ID register
  // -------------------------------------------------------------------------
  logic [31:0]        r_pc_p1;
  logic [31:0]        r_ins_p1;
  logic [6:0]         r_opcode_p1;
  logic [2:0]         r_funct3_p1;
  logic [6:0]         r_funct7_p1;
  logic [4:0]         r_rs1_p1;
  logic [4:0]         r_rs2_p1;
  logic [4:0]         r_rd_p1;
  logic signed [31:0] r_imm_p1;
  logic [31:0]        r_rs1_data_p1;
  logic [31:0]        r_rs2_data_p1;
  logic               r_ill_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p1      <= 1'b0;
      r_pc_p1       <= 32'h0;
      r_ins_p1      <= NOP_INSTR;
      r_opcode_p1   <= 7'h0;
      r_funct3_p1   <= 3'h0;
      r_funct7_p1   <= 7'h0;
      r_rs1_p1      <= 5'h0;
      r_rs2_p1      <= 5'h0;
      r_rd_p1       <= 5'h0;
      r_imm_p1      <= 32'sd0;
      r_rs1_data_p1 <= 32'h0;
      r_rs2_data_p1 <= 32'h0;
      r_ill_p1      <= 1'b0;
    end else if (bus.flush || (w_drain && !w_load)) begin
      // Bubble: the outputs show the decode of the NOP word.
      r_vld_p1      <= 1'b0;
      r_pc_p1       <= 32'h0;
      r_ins_p1      <= NOP_INSTR;
      r_opcode_p1   <= NOP_INSTR[6:0];
      r_funct3_p1   <= NOP_INSTR[14:12];
      r_funct7_p1   <= NOP_INSTR[31:25];
      r_rs1_p1      <= NOP_INSTR[19:15];
      r_rs2_p1      <= NOP_INSTR[24:20];
      r_rd_p1       <= NOP_INSTR[11:7];
      r_imm_p1      <= f_imm(NOP_INSTR);
      r_rs1_data_p1 <= 32'h0;
      r_rs2_data_p1 <= 32'h0;
      r_ill_p1      <= 1'b0;
    end else if (w_load) begin
      r_vld_p1      <= 1'b1;
      r_pc_p1       <= bus.if_pc;
      r_ins_p1      <= w_ins_p0;
      r_opcode_p1   <= w_ins_p0[6:0];
      r_funct3_p1   <= w_ins_p0[14:12];
      r_funct7_p1   <= w_ins_p0[31:25];
      r_rs1_p1      <= w_rs1_p0;
      r_rs2_p1      <= w_rs2_p0;
      r_rd_p1       <= w_rd_p0;
      r_imm_p1      <= w_imm_p0;
      r_rs1_data_p1 <= w_rs1_data_p0;
      r_rs2_data_p1 <= w_rs2_data_p0;
      r_ill_p1      <= w_ill_p0;
    end else if (r_vld_p1) begin
      // Stalled entry: keep the operands coherent with the register file, so
      // that execute sees writebacks that retire while decode is blocked.
      if (w_wr_en && (bus.wb_rd == r_rs1_p1)) r_rs1_data_p1 <= bus.wb_data;
      if (w_wr_en && (bus.wb_rd == r_rs2_p1)) r_rs2_data_p1 <= bus.wb_data;
    end
  end

  assign bus.id_ready       = w_ready;
  assign bus.id_valid       = r_vld_p1;
  assign bus.id_pc          = r_pc_p1;
  assign bus.id_instruction = r_ins_p1;
  assign bus.id_opcode      = r_opcode_p1;
  assign bus.id_funct3      = r_funct3_p1;
  assign bus.id_funct7      = r_funct7_p1;
  assign bus.id_rs1         = r_rs1_p1;
  assign bus.id_rs2         = r_rs2_p1;
  assign bus.id_rd          = r_rd_p1;
  assign bus.id_imm         = r_imm_p1;
  assign bus.id_rs1_data    = r_rs1_data_p1;
  assign bus.id_rs2_data    = r_rs2_data_p1;
  assign bus.id_illegal     = r_ill_p1;

endmodule
